jt900h_shift_seq: RTL and testbench

//  Multi-cycle sequencer for the TLCS-900H rotate/shift group (RLC,RRC,RL,RR,SLA,SRA,SLL,SRL) with counts 1..16.

---
 rtl/jt900h_shift_seq_pkg.sv | 53 +++++
 rtl/jt900h_shift_seq_if.sv | 33 +++
 rtl/jt900h_shift_seq.sv | 109 ++++++++++
 tb/tb_jt900h_shift_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jt900h_shift_seq_pkg.sv
// Shared codes for the TLCS-900H rotate/shift sequencer and the ALU it drives:
// alu_sel / carry_sel encodings, shift kinds, FSM states and width helpers.
package jt900h_shift_seq_pkg;

   localparam logic [3:0] NOP_ALU = 4'd0;
   localparam logic [3:0] SHL_ALU = 4'd10;
   localparam logic [3:0] SHR_ALU = 4'd11;

   localparam logic [2:0] ZERO_CARRY = 3'd0;
   localparam logic [2:0] CIN_CARRY  = 3'd1;
   localparam logic [2:0] SA_CARRY   = 3'd2;
   localparam logic [2:0] SH_CARRY   = 3'd3;

   typedef enum logic [2:0] {
      RLC = 3'd0, RRC = 3'd1, RL = 3'd2, RR = 3'd3,
      SLA = 3'd4, SRA = 3'd5, SLL = 3'd6, SRL = 3'd7
   } shift_kind_t;

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   // bs wins over ws; neither set means long
   function automatic logic [31:0] width_mask(input logic bs, input logic ws);
      logic [31:0] m;
      m = bs ? 32'h0000_00FF : (ws ? 32'h0000_FFFF : 32'hFFFF_FFFF);
      return m;
   endfunction

   function automatic logic width_msb(input logic [31:0] v, input logic bs, input logic ws);
      logic b;
      b = bs ? v[7] : (ws ? v[15] : v[31]);
      return b;
   endfunction

   function automatic logic is_left(input shift_kind_t k);
      logic l;
      l = (k == RLC) || (k == RL) || (k == SLA) || (k == SLL);
      return l;
   endfunction

   // SA_CARRY feeds the width MSB: rotate-in for RLC, sign-fill for SRA
   function automatic logic [2:0] carry_for(input shift_kind_t k);
      logic [2:0] cs;
      cs = ZERO_CARRY;
      case (k)
         RLC, SRA: cs = SA_CARRY;
         RRC:      cs = SH_CARRY;
         RL, RR:   cs = CIN_CARRY;
         default:  cs = ZERO_CARRY;
      endcase
      return cs;
   endfunction

endpackage

// File: rtl/jt900h_shift_seq_if.sv
// Decoder/ALU-facing signal bundle of the rotate/shift sequencer.
interface jt900h_shift_seq_if;
   logic        cen;
   logic        start;
   logic [2:0]  kind;
   logic [3:0]  cnt;
   logic        bs;
   logic        ws;
   logic [31:0] din;
   logic        cin;
   logic [31:0] alu_rslt;
   logic [31:0] alu_op2;
   logic [3:0]  alu_sel;
   logic [2:0]  carry_sel;
   logic        alu_cin;
   logic        busy;
   logic        done;
   logic [31:0] rslt;
   logic        c;
   logic        z;
   logic        n;
   logic        p;

   modport slave (
      input  cen, start, kind, cnt, bs, ws, din, cin, alu_rslt,
      output alu_op2, alu_sel, carry_sel, alu_cin, busy, done, rslt, c, z, n, p
   );

   modport master (
      output cen, start, kind, cnt, bs, ws, din, cin, alu_rslt,
      input  alu_op2, alu_sel, carry_sel, alu_cin, busy, done, rslt, c, z, n, p
   );
endinterface

// File: rtl/jt900h_shift_seq.sv
// Multi-cycle sequencer for RLC/RRC/RL/RR/SLA/SRA/SLL/SRL, one ALU bit-shift per cen step.
// Define JT900H_SHIFT_PV_EN to produce the even-parity P/V flag; otherwise p is tied 0.
module jt900h_shift_seq
   import jt900h_shift_seq_pkg::*;
(
   input logic               clk,
   input logic               rst,
   jt900h_shift_seq_if.slave sif
);

   state_t      st, st_nxt;
   shift_kind_t kind_l;
   logic [31:0] work, din_l;
   logic [31:0] mask, res_nxt, rslt_q;
   logic [4:0]  rem;
   logic        crr, bs_l, ws_l;
   logic        accept, out_bit;
   logic        c_q, z_q, n_q;
   logic [3:0]  sel_w;
   logic [2:0]  csel_w;

   assign accept  = sif.start && (st == IDLE || st == DONE);
   assign mask    = width_mask(bs_l, ws_l);
   assign out_bit = is_left(kind_l) ? width_msb(work, bs_l, ws_l) : work[0];
   // bits above the operand width come from the original operand, not the ALU
   assign res_nxt = (din_l & ~mask) | (sif.alu_rslt & mask);

   always_ff @(posedge clk) begin
      if (rst)           st <= IDLE;
      else if (sif.cen)  st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      sel_w  = NOP_ALU;
      csel_w = ZERO_CARRY;
      case (st)
         IDLE:  if (sif.start) st_nxt = SHIFT;
         SHIFT: begin
            sel_w  = is_left(kind_l) ? SHL_ALU : SHR_ALU;
            csel_w = carry_for(kind_l);
            if (rem == 5'd1) st_nxt = DONE;
         end
         DONE:    st_nxt = sif.start ? SHIFT : IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         work   <= '0;
         din_l  <= '0;
         crr    <= 1'b0;
         rem    <= '0;
         kind_l <= RLC;
         bs_l   <= 1'b0;
         ws_l   <= 1'b0;
         rslt_q <= '0;
         c_q    <= 1'b0;
         z_q    <= 1'b0;
         n_q    <= 1'b0;
      end else if (sif.cen) begin
         if (accept) begin
            work   <= sif.din;
            din_l  <= sif.din;
            crr    <= sif.cin;
            rem    <= {sif.cnt == 4'd0, sif.cnt};
            kind_l <= shift_kind_t'(sif.kind);
            bs_l   <= sif.bs;
            ws_l   <= sif.ws;
         end else if (st == SHIFT) begin
            work <= sif.alu_rslt;
            crr  <= out_bit;
            rem  <= rem - 5'd1;
            if (rem == 5'd1) begin
               rslt_q <= res_nxt;
               c_q    <= out_bit;
               z_q    <= ~|(res_nxt & mask);
               n_q    <= width_msb(res_nxt, bs_l, ws_l);
            end
         end
      end
   end

`ifdef JT900H_SHIFT_PV_EN
   logic p_q;
   always_ff @(posedge clk) begin
      if (rst)
         p_q <= 1'b0;
      else if (sif.cen && st == SHIFT && rem == 5'd1)
         p_q <= ~^(res_nxt & mask);
   end
   assign sif.p = p_q;
`else
   assign sif.p = 1'b0;
`endif

   assign sif.alu_op2   = work;
   assign sif.alu_cin   = crr;
   assign sif.alu_sel   = sel_w;
   assign sif.carry_sel = csel_w;
   assign sif.busy      = (st == SHIFT);
   assign sif.done      = (st == DONE);
   assign sif.rslt      = rslt_q;
   assign sif.c         = c_q;
   assign sif.z         = z_q;
   assign sif.n         = n_q;

endmodule

// File: tb/tb_jt900h_shift_seq.sv
// Randomized scoreboard bench for jt900h_shift_seq with a behavioural one-bit shift ALU.
module tb_jt900h_shift_seq;
   import jt900h_shift_seq_pkg::*;

   typedef struct {
      logic [31:0] rslt;
      logic        c, z, n, p;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   jt900h_shift_seq_if sif();

   jt900h_shift_seq dut (.clk(clk), .rst(rst), .sif(sif));

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   int   cen_mode = 0;
   logic tb_bs = 1'b0, tb_ws = 1'b0;
   logic [31:0] garb = '0;

   // ALU: single-bit shift within width, junk above the width
   logic [31:0] alu_m, alu_r;
   logic        alu_msb, alu_in;
   always_comb begin
      alu_m   = tb_bs ? 32'hFF : (tb_ws ? 32'hFFFF : 32'hFFFF_FFFF);
      alu_msb = tb_bs ? sif.alu_op2[7] : (tb_ws ? sif.alu_op2[15] : sif.alu_op2[31]);
      alu_in  = 1'b0;
      case (sif.carry_sel)
         CIN_CARRY: alu_in = sif.alu_cin;
         SA_CARRY:  alu_in = alu_msb;
         SH_CARRY:  alu_in = sif.alu_op2[0];
         default:   alu_in = 1'b0;
      endcase
      alu_r = sif.alu_op2;
      if (sif.alu_sel == SHL_ALU)
         alu_r = {sif.alu_op2[30:0], alu_in};
      else if (sif.alu_sel == SHR_ALU) begin
         alu_r = {1'b0, sif.alu_op2[31:1]};
         if (tb_bs)      alu_r[7]  = alu_in;
         else if (tb_ws) alu_r[15] = alu_in;
         else            alu_r[31] = alu_in;
      end
      sif.alu_rslt = (alu_r & alu_m) | (garb & ~alu_m);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference: whole-count rotates/shifts with 64-bit arithmetic
   function automatic exp_t ref_model(input int k, input int n, input bit b, input bit w16,
                                      input logic [31:0] d, input bit ci);
      exp_t e;
      int w, kk;
      longint unsigned v, m, x, y, mm, r;
      longint sv;
      bit cy;
      w  = b ? 8 : (w16 ? 16 : 32);
      m  = (64'd1 << w) - 1;
      mm = (64'd1 << (w + 1)) - 1;
      v  = {32'd0, d} & m;
      x  = ({63'd0, ci} << w) | v;
      r  = 0;
      cy = 0;
      case (k)
         0: begin kk = n % w; r = ((v << kk) | (v >> (w - kk))) & m; cy = r[0]; end
         1: begin kk = n % w; r = ((v >> kk) | (v << (w - kk))) & m; cy = 1'((r >> (w - 1)) & 1); end
         2: begin kk = n % (w + 1); y = ((x << kk) | (x >> (w + 1 - kk))) & mm; r = y & m; cy = 1'(y >> w); end
         3: begin kk = n % (w + 1); y = ((x >> kk) | (x << (w + 1 - kk))) & mm; r = y & m; cy = 1'(y >> w); end
         4, 6: begin r = (v << n) & m; cy = (n <= w) ? 1'((v >> (w - n)) & 1) : 1'b0; end
         5: begin
            sv = $signed(v << (64 - w)) >>> (64 - w);
            r  = $unsigned(sv >>> n) & m;
            cy = 1'($unsigned(sv >>> (n - 1)) & 1);
         end
         default: begin r = v >> n; cy = 1'((v >> (n - 1)) & 1); end
      endcase
      e.rslt = (d & ~m[31:0]) | r[31:0];
      e.c    = cy;
      e.z    = (r == 0);
      e.n    = 1'((r >> (w - 1)) & 1);
`ifdef JT900H_SHIFT_PV_EN
      e.p    = ~^r[31:0];
`else
      e.p    = 1'b0;
`endif
      return e;
   endfunction

   // monitor: pops one expectation per done pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sif.done && sif.cen) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL done_unexpected actual=1 expected=0 t=%0t", $time);
            end else begin
               e = q.pop_front();
               chk("rslt", sif.rslt, e.rslt);
               chk("c", 32'(sif.c), 32'(e.c));
               chk("z", 32'(sif.z), 32'(e.z));
               chk("n", 32'(sif.n), 32'(e.n));
               chk("p", 32'(sif.p), 32'(e.p));
            end
         end
      end
   end

   // cen pattern generator
   initial begin
      int ph = 0;
      sif.cen = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (cen_mode)
            0: sif.cen = 1'b1;
            1: begin ph = (ph + 1) % 4; sif.cen = (ph == 0); end
            default: sif.cen = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic do_op(input logic [2:0] k, input logic [3:0] cn, input bit b, input bit w16,
                        input logic [31:0] d, input bit ci, input bit junk);
      exp_t e;
      int nb, g, n;
      bit acc;
      n = (cn == 0) ? 16 : int'(cn);
      e = ref_model(int'(k), n, b, w16, d, ci);
      tb_bs = b; tb_ws = w16; garb = $urandom;
      sif.kind = k; sif.cnt = cn; sif.bs = b; sif.ws = w16; sif.din = d; sif.cin = ci;
      sif.start = 1'b1;
      acc = 0; g = 0;
      while (!acc && g < 50) begin @(posedge clk); acc = sif.cen; g++; end
      if (!acc) begin
         sif.start = 1'b0;
         chk("accept_timeout", 32'(acc), 32'd1);
         return;
      end
      q.push_back(e);
      #1;
      sif.start = 1'b0; sif.din = $urandom; sif.kind = 3'($urandom); sif.cin = 1'($urandom);
      nb = 0; g = 0;
      forever begin
         @(negedge clk);
         g++;
         sif.start = 1'b0;
         if (sif.cen && sif.done) break;
         if (sif.cen && sif.busy) nb++;
         if (g > 400) begin chk("done_timeout", 32'(g), 32'd0); break; end
         if (junk && sif.busy && $urandom_range(0, 2) == 0) begin
            sif.start = 1'b1; sif.din = $urandom; sif.cnt = 4'($urandom);
         end
      end
      chk("busy_cycles", 32'(nb), 32'(n));
      chk("busy_at_done", 32'(sif.busy), 32'd0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_busy"}, 32'(sif.busy), 32'd0);
      chk({tag, "_done"}, 32'(sif.done), 32'd0);
      chk({tag, "_rslt"}, sif.rslt, 32'd0);
      chk({tag, "_flags"}, {28'd0, sif.c, sif.z, sif.n, sif.p}, 32'd0);
      chk({tag, "_op2"}, sif.alu_op2, 32'd0);
      chk({tag, "_cin"}, 32'(sif.alu_cin), 32'd0);
      chk({tag, "_sel"}, 32'(sif.alu_sel), 32'(NOP_ALU));
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      sif.start = 1'b0; sif.kind = '0; sif.cnt = '0; sif.bs = 1'b0; sif.ws = 1'b0;
      sif.din = '0; sif.cin = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);

      // directed cases
      do_op(3'd4, 4'd1, 1, 0, 32'hABCD_0081, 0, 0);   // SLA byte
      do_op(3'd0, 4'd4, 0, 1, 32'h5A5A_8001, 0, 0);   // RLC word
      do_op(3'd1, 4'd0, 0, 1, 32'h0000_1234, 0, 0);   // RRC word x16
      do_op(3'd5, 4'd3, 1, 0, 32'h1234_5680, 0, 0);   // SRA byte
      do_op(3'd2, 4'd1, 0, 0, 32'h0000_0000, 1, 1);   // RL long, junk starts
      cen_mode = 1;
      do_op(3'd0, 4'd4, 0, 1, 32'h5A5A_8001, 0, 0);   // stretched timing
      cen_mode = 0;

      // abort mid-operation with reset
      do_op(3'd7, 4'd2, 1, 0, 32'h0000_00F0, 0, 0);
      tb_bs = 1'b0; tb_ws = 1'b0;
      sif.kind = 3'd6; sif.cnt = 4'd8; sif.bs = 1'b0; sif.ws = 1'b0; sif.din = 32'hDEAD_BEEF;
      sif.start = 1'b1;
      @(posedge clk);
      #1 sif.start = 1'b0;
      nb = 0;
      while (nb < 2) begin @(negedge clk); if (sif.busy) nb++; end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_reset_state("abort");
      repeat (4) @(negedge clk);
      chk("abort_idle_busy", 32'(sif.busy), 32'd0);

      // randomized operations
      for (int i = 0; i < 150; i++) begin
         int wsel;
         cen_mode = $urandom_range(0, 2);
         wsel = $urandom_range(0, 2);
         do_op(3'($urandom), 4'($urandom), wsel == 0, wsel == 1, $urandom,
               1'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      cen_mode = 0;
      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
